// File: rtl/grid_dumper_pkg.sv
// grid_dumper_pkg
// Shared widths, the dump FSM state type and the ASCII constants used by the
// grid dumper and any later emitter that writes the puzzle's text form.
package grid_dumper_pkg;

  localparam int BANK_DEPTH      = 256;
  localparam int BANK_ADDR_WIDTH = 8;
  localparam int MAX_COLS        = 256;
  localparam int COL_ADDR_WIDTH  = 8;
  localparam int TX_DATA_WIDTH   = 8;
  // Width of the bit index inside one partial vector (at least one bit).
  localparam int BIT_IDX_WIDTH   = (TX_DATA_WIDTH > 1) ? $clog2(TX_DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RELEASE,
    ST_EMIT,
    ST_NEWLINE,
    ST_DONE
  } dump_state_t;

  localparam logic [7:0] CHAR_AT  = 8'h40;  // '@' occupied cell
  localparam logic [7:0] CHAR_DOT = 8'h2E;  // '.' empty cell
  localparam logic [7:0] CHAR_NL  = 8'h0A;  // end of row

  function automatic logic [7:0] cell_char(input logic occupied);
    return occupied ? CHAR_AT : CHAR_DOT;
  endfunction

endpackage

// File: rtl/grid_dumper_chunk_serializer.sv
// chunk_serializer
// Holds one partial vector returned by the bank and walks its bits one at a
// time as the top FSM hands bytes off downstream.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   load_i         : capture vec_i, restart at bit 0 and column base_col_i
//   vec_i          : partial vector from the bank (bit i = column base+i)
//   base_col_i     : column of bit 0 of vec_i
//   advance_i      : step to the next bit/column
//   cur_bit_o      : bit at the current index
//   next_bit_o     : bit at the following index (pre-computes the next byte)
//   last_bit_o     : current index is the top bit of the chunk
//   last_col_o     : current column is the last column of the grid row
module chunk_serializer
  import grid_dumper_pkg::*;
#(
  parameter int NUM_COLS = MAX_COLS
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic [TX_DATA_WIDTH-1:0]  vec_i,
  input  logic [COL_ADDR_WIDTH-1:0] base_col_i,
  input  logic                      advance_i,
  output logic                      cur_bit_o,
  output logic                      next_bit_o,
  output logic                      last_bit_o,
  output logic                      last_col_o
);

  logic [TX_DATA_WIDTH-1:0]  chunk_q, chunk_d;
  logic [BIT_IDX_WIDTH-1:0]  bit_idx_q, bit_idx_d;
  logic [COL_ADDR_WIDTH-1:0] col_q, col_d;
  logic [BIT_IDX_WIDTH-1:0]  next_idx;

  always_comb begin
    chunk_d   = chunk_q;
    bit_idx_d = bit_idx_q;
    col_d     = col_q;
    if (load_i) begin
      chunk_d   = vec_i;
      bit_idx_d = '0;
      col_d     = base_col_i;
    end else if (advance_i) begin
      bit_idx_d = bit_idx_q + BIT_IDX_WIDTH'(1);
      col_d     = col_q + COL_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      chunk_q   <= '0;
      bit_idx_q <= '0;
      col_q     <= '0;
    end else begin
      chunk_q   <= chunk_d;
      bit_idx_q <= bit_idx_d;
      col_q     <= col_d;
    end
  end

  // next_idx wraps on the top bit; next_bit_o is only consumed when not last.
  assign next_idx   = bit_idx_q + BIT_IDX_WIDTH'(1);
  assign cur_bit_o  = chunk_q[bit_idx_q];
  assign next_bit_o = chunk_q[next_idx];
  assign last_bit_o = (bit_idx_q == BIT_IDX_WIDTH'(TX_DATA_WIDTH - 1));
  assign last_col_o = (col_q == COL_ADDR_WIDTH'(NUM_COLS - 1));

endmodule

// File: rtl/grid_dumper.sv
// grid_dumper
// Walks the grid held in the bank row by row and chunk by chunk, reading each
// partial vector over the request/ack port and serialising it as ASCII
// ('@', '.', newline) on a valid/ready byte stream, counting '@' bytes.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   start                     : begin a dump (only honoured in IDLE)
//   ack_in, busy_in           : bank response / bank busy
//   partial_vec_in            : bank read data, bit i = column col_addr_out+i
//   read_en_out, write_en_out : bank request (write is always 0)
//   row_addr_out, col_addr_out: requested row / chunk base column
//   byte_out, byte_valid_out, byte_ready_in : ASCII output stream
//   count_out                 : '@' bytes emitted in the current/last dump
//   busy_out, done_out        : not idle / final newline accepted pulse
module grid_dumper
  import grid_dumper_pkg::*;
#(
  parameter int NUM_ROWS = BANK_DEPTH,
  parameter int NUM_COLS = MAX_COLS
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       ack_in,
  input  logic                       busy_in,
  input  logic [TX_DATA_WIDTH-1:0]   partial_vec_in,
  output logic                       read_en_out,
  output logic                       write_en_out,
  output logic [BANK_ADDR_WIDTH-1:0] row_addr_out,
  output logic [COL_ADDR_WIDTH-1:0]  col_addr_out,
  output logic [7:0]                 byte_out,
  output logic                       byte_valid_out,
  input  logic                       byte_ready_in,
  output logic [31:0]                count_out,
  output logic                       busy_out,
  output logic                       done_out
);

  dump_state_t                state_q;
  logic                       read_en_q;
  logic [BANK_ADDR_WIDTH-1:0] row_q;
  logic [COL_ADDR_WIDTH-1:0]  col_addr_q;
  logic [7:0]                 byte_q;
  logic                       byte_valid_q;
  logic [31:0]                count_q;
  logic                       busy_q;
  logic                       done_q;

  logic handshake;
  logic ser_load, ser_advance;
  logic cur_bit, next_bit, last_bit, last_col;

  assign handshake   = byte_valid_q & byte_ready_in;
  // Capture the chunk in the ack cycle; a stale ack outside REQ is ignored.
  assign ser_load    = (state_q == ST_REQ) && ack_in;
  assign ser_advance = (state_q == ST_EMIT) && handshake && !last_col && !last_bit;

  chunk_serializer #(
    .NUM_COLS (NUM_COLS)
  ) u_ser (
    .clock      (clock),
    .reset      (reset),
    .load_i     (ser_load),
    .vec_i      (partial_vec_in),
    .base_col_i (col_addr_q),
    .advance_i  (ser_advance),
    .cur_bit_o  (cur_bit),
    .next_bit_o (next_bit),
    .last_bit_o (last_bit),
    .last_col_o (last_col)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      read_en_q    <= 1'b0;
      row_q        <= '0;
      col_addr_q   <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            row_q      <= '0;
            col_addr_q <= '0;
            count_q    <= '0;
            read_en_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (ack_in) begin
            read_en_q <= 1'b0;
            state_q   <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          // The bank must drop ack and busy before the next access is legal.
          if (!ack_in && !busy_in) begin
            byte_q       <= cell_char(cur_bit);
            byte_valid_q <= 1'b1;
            state_q      <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          if (handshake) begin
            if (byte_q == CHAR_AT && count_q != 32'hFFFF_FFFF) begin
              count_q <= count_q + 32'd1;
            end
            // Last column wins over last bit so padding bits are never shown.
            if (last_col) begin
              byte_q  <= CHAR_NL;
              state_q <= ST_NEWLINE;
            end else if (last_bit) begin
              byte_valid_q <= 1'b0;
              col_addr_q   <= col_addr_q + COL_ADDR_WIDTH'(TX_DATA_WIDTH);
              read_en_q    <= 1'b1;
              state_q      <= ST_REQ;
            end else begin
              byte_q <= cell_char(next_bit);
            end
          end
        end
        ST_NEWLINE: begin
          if (handshake) begin
            byte_valid_q <= 1'b0;
            if (row_q == BANK_ADDR_WIDTH'(NUM_ROWS - 1)) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              row_q      <= row_q + BANK_ADDR_WIDTH'(1);
              col_addr_q <= '0;
              read_en_q  <= 1'b1;
              state_q    <= ST_REQ;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign read_en_out    = read_en_q;
  assign write_en_out   = 1'b0;
  assign row_addr_out   = row_q;
  assign col_addr_out   = col_addr_q;
  assign byte_out       = byte_q;
  assign byte_valid_out = byte_valid_q;
  assign count_out      = count_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;

endmodule

// File: tb/tb_grid_dumper.sv
module tb_grid_dumper;
  import grid_dumper_pkg::*;

  localparam int NR = 2;
  localparam int NC = TX_DATA_WIDTH + 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                       reset = 1'b1;
  logic                       start = 1'b0;
  logic                       ack_in = 1'b0;
  logic                       busy_in = 1'b0;
  logic [TX_DATA_WIDTH-1:0]   partial_vec_in = '0;
  logic                       read_en_out, write_en_out;
  logic [BANK_ADDR_WIDTH-1:0] row_addr_out;
  logic [COL_ADDR_WIDTH-1:0]  col_addr_out;
  logic [7:0]                 byte_out;
  logic                       byte_valid_out;
  logic                       byte_ready_in = 1'b1;
  logic [31:0]                count_out;
  logic                       busy_out, done_out;

  grid_dumper #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clock(clock), .reset(reset), .start(start), .ack_in(ack_in),
    .busy_in(busy_in), .partial_vec_in(partial_vec_in),
    .read_en_out(read_en_out), .write_en_out(write_en_out),
    .row_addr_out(row_addr_out), .col_addr_out(col_addr_out),
    .byte_out(byte_out), .byte_valid_out(byte_valid_out),
    .byte_ready_in(byte_ready_in), .count_out(count_out),
    .busy_out(busy_out), .done_out(done_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bank contents: bits 0..NC-1 are cells, upper bits are padding set to 1.
  logic [2*TX_DATA_WIDTH-1:0] mem [NR];
  logic [7:0] sb [$];
  int exp_count;

  // ---------------- bank model ----------------
  int ack_delay = 0, busy_hold = 0;
  int phase = 0, cnt = 0, req_idx = 0;
  logic [BANK_ADDR_WIDTH-1:0] req_row;
  logic [COL_ADDR_WIDTH-1:0]  req_col;

  always @(negedge clock) begin
    if (reset) begin
      phase = 0; ack_in = 1'b0; busy_in = 1'b0;
    end else begin
      case (phase)
        0: if (read_en_out) begin
          req_row = row_addr_out;
          req_col = col_addr_out;
          check("req_row", 32'(row_addr_out), 32'(req_idx / 2));
          check("req_col", 32'(col_addr_out), 32'((req_idx % 2) * TX_DATA_WIDTH));
          check("write_en", 32'(write_en_out), 32'd0);
          req_idx++;
          busy_in = 1'b1;
          cnt = ack_delay;
          phase = 1;
        end
        1: begin
          check("read_en_hold", 32'(read_en_out), 32'd1);
          check("row_stable", 32'(row_addr_out), 32'(req_row));
          check("col_stable", 32'(col_addr_out), 32'(req_col));
          if (cnt == 0) begin
            ack_in = 1'b1;
            if (int'(req_row) < NR) partial_vec_in = mem[req_row[0]][req_col +: TX_DATA_WIDTH];
            else partial_vec_in = '0;
            phase = 2;
          end else cnt--;
        end
        2: begin
          check("read_en_drop", 32'(read_en_out), 32'd0);
          ack_in = 1'b0;
          cnt = busy_hold;
          phase = 3;
        end
        default: begin
          check("no_byte_while_busy", 32'(byte_valid_out), 32'd0);
          if (cnt == 0) begin busy_in = 1'b0; phase = 0; end
          else cnt--;
        end
      endcase
    end
  end

  // ---------------- byte consumer / scoreboard ----------------
  int stall_at = -1, stall_len = 0, stall_left = 0;
  int popped = 0, done_cnt = 0;
  logic [7:0] held;
  logic [7:0] exp_b;

  always @(negedge clock) begin
    if (done_out) done_cnt++;
    if (popped == stall_at && stall_left > 0 && (byte_valid_out || stall_left != stall_len)) begin
      byte_ready_in = 1'b0;
      if (stall_left == stall_len) held = byte_out;
      else begin
        check("stall_valid", 32'(byte_valid_out), 32'd1);
        check("stall_byte", 32'(byte_out), 32'(held));
      end
      stall_left--;
    end else begin
      byte_ready_in = 1'b1;
      if (byte_valid_out) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $error("FAIL extra_byte: observed %0h expected none", byte_out);
        end else begin
          exp_b = sb.pop_front();
          check("byte", 32'(byte_out), 32'(exp_b));
        end
        popped++;
      end
    end
  end

  task automatic push_stream();
    exp_count = 0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        sb.push_back(mem[r][c] ? 8'h40 : 8'h2E);
        if (mem[r][c]) exp_count++;
      end
      sb.push_back(8'h0A);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_popped(input int n);
    int i;
    for (i = 0; i < 2000 && popped < n; i++) @(negedge clock);
    check("wait_popped_timeout", 32'(popped >= n), 32'd1);
  endtask

  task automatic finish_dump(input string tag);
    int i;
    for (i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clock);
    repeat (4) @(negedge clock);
    $display("%s: bytes=%0d count_out=%0d done_pulses=%0d reads=%0d", tag, popped, count_out, done_cnt, req_idx);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({tag, "_count"}, count_out, 32'(exp_count));
    check({tag, "_busy_idle"}, 32'(busy_out), 32'd0);
    check({tag, "_reads"}, 32'(req_idx), 32'(NR * 2));
  endtask

  task automatic prep(input int ad, input int bh, input int s_at, input int s_len);
    ack_delay = ad; busy_hold = bh;
    stall_at = s_at; stall_len = s_len; stall_left = s_len;
    popped = 0; done_cnt = 0; req_idx = 0;
    sb.delete();
    push_stream();
  endtask

  initial begin
    mem[0] = {6'h3F, 10'b10_0100_1101};
    mem[1] = {6'h3F, 10'b01_1011_0010};

    repeat (2) @(posedge clock);
    #1;
    check("rst_read_en", 32'(read_en_out), 32'd0);
    check("rst_write_en", 32'(write_en_out), 32'd0);
    check("rst_valid", 32'(byte_valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_done", 32'(done_out), 32'd0);
    check("rst_row", 32'(row_addr_out), 32'd0);
    check("rst_col", 32'(col_addr_out), 32'd0);
    check("rst_byte", 32'(byte_out), 32'd0);
    check("rst_count", count_out, 32'd0);
    @(negedge clock); reset = 1'b0;

    // Dump 1: immediate ack, no stalls; also check start-to-request latency.
    prep(0, 0, -1, 0);
    @(negedge clock); start = 1'b1;
    @(posedge clock); #1;
    check("start_read_en", 32'(read_en_out), 32'd1);
    check("start_busy", 32'(busy_out), 32'd1);
    check("start_count_clear", count_out, 32'd0);
    @(negedge clock); start = 1'b0;
    finish_dump("dump1");

    // Dump 2: slow bank, ready stall on the second byte, start pulsed mid-dump.
    prep(4, 2, 1, 5);
    pulse_start();
    wait_popped(6);
    check("busy_mid_dump", 32'(busy_out), 32'd1);
    pulse_start();
    finish_dump("dump2");

    // Dump 3: reset while emitting, then a fresh dump from row 0 col 0.
    prep(0, 0, -1, 0);
    pulse_start();
    wait_popped(3);
    check("in_emit", 32'(byte_valid_out), 32'd1);
    reset = 1'b1;
    @(posedge clock); #1;
    check("mid_rst_read_en", 32'(read_en_out), 32'd0);
    check("mid_rst_valid", 32'(byte_valid_out), 32'd0);
    check("mid_rst_busy", 32'(busy_out), 32'd0);
    check("mid_rst_done", 32'(done_out), 32'd0);
    check("mid_rst_row", 32'(row_addr_out), 32'd0);
    check("mid_rst_col", 32'(col_addr_out), 32'd0);
    check("mid_rst_byte", 32'(byte_out), 32'd0);
    check("mid_rst_count", count_out, 32'd0);
    @(negedge clock);
    @(posedge clock); #1 reset = 1'b0;
    prep(1, 1, -1, 0);
    pulse_start();
    finish_dump("dump3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
